// File: rtl/bus_master_if.sv
// Host handshake and SRAM control/address signals for bus_master.
// master: the bus_master side (takes host requests, drives SRAM strobes).
// slave : the host / SRAM-model side.
// The bidirectional sram_data bus is a plain inout on bus_master itself.
interface bus_master_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 19
);
  logic              req;
  logic              rnw;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic              ack;
  logic              busy;
  logic [AWIDTH-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport master (
    input  req, rnw, addr, wdata,
    output rdata, ack, busy, sram_addr, sram_ce_n, sram_we_n, sram_oe_n
  );

  modport slave (
    output req, rnw, addr, wdata,
    input  rdata, ack, busy, sram_addr, sram_ce_n, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/bus_master.sv
// bus_master: initiator side of an asynchronous SRAM WE/OE strobe protocol.
// A host request taken in IDLE runs SETUP -> STROBE -> HOLD, each phase
// timed by a 4-bit down-counter, then returns to IDLE with a one-cycle ack.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (master)   : req/rnw/addr/wdata in; rdata/ack/busy, sram_addr,
//                    sram_ce_n/we_n/oe_n out
//   sram_data      : bidirectional data bus, driven only during writes
module bus_master #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 19,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              reset,
  bus_master_if.master      bus,
  inout  wire  [DWIDTH-1:0] sram_data
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_STROBE = 4'b0100,
    ST_HOLD   = 4'b1000
  } state_t;

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP  - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD   - 1);

  state_t            r_state, w_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_cap, w_smp, w_done, w_act, w_rnw;

  logic              r_rnw;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_rdata;
  logic [AWIDTH-1:0] r_addr;
  logic              r_ack, r_busy, r_ce_n, r_we_n, r_oe_n, r_drv;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_cap     = 1'b0;
    w_smp     = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.req) begin
        w_nxt     = ST_SETUP;
        w_cnt_nxt = SETUP_LD;
        w_cap     = 1'b1;
      end
      ST_SETUP: if (r_cnt == 4'd0) begin
        w_nxt     = ST_STROBE;
        w_cnt_nxt = STROBE_LD;
      end else w_cnt_nxt = r_cnt - 4'd1;
      ST_STROBE: if (r_cnt == 4'd0) begin
        w_nxt     = ST_HOLD;
        w_cnt_nxt = HOLD_LD;
        w_smp     = r_rnw;           // read data is taken as OE rises
      end else w_cnt_nxt = r_cnt - 4'd1;
      ST_HOLD: if (r_cnt == 4'd0) begin
        w_nxt     = ST_IDLE;
        w_done    = 1'b1;
      end else w_cnt_nxt = r_cnt - 4'd1;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with
  // the state they belong to, without any input-to-strobe comb path.
  assign w_act = (w_nxt != ST_IDLE);
  assign w_rnw = w_cap ? bus.rnw : r_rnw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rnw   <= 1'b1;
      r_wdata <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_drv   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_rnw   <= bus.rnw;
        r_wdata <= bus.wdata;
        r_addr  <= bus.addr;
      end
      if (w_smp) r_rdata <= sram_data;
      r_ack  <= w_done;
      r_busy <= w_act;
      r_ce_n <= ~w_act;
      r_we_n <= ~((w_nxt == ST_STROBE) && !w_rnw);
      r_oe_n <= ~((w_nxt == ST_STROBE) &&  w_rnw);
      r_drv  <= w_act && !w_rnw;     // writes drive through SETUP..HOLD
    end
  end

  assign sram_data     = r_drv ? r_wdata : 'z;
  assign bus.rdata     = r_rdata;
  assign bus.ack       = r_ack;
  assign bus.busy      = r_busy;
  assign bus.sram_addr = r_addr;
  assign bus.sram_ce_n = r_ce_n;
  assign bus.sram_we_n = r_we_n;
  assign bus.sram_oe_n = r_oe_n;

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameters SHALL be:
- DWIDTH, 8, data width
- AWIDTH, 19, SRAM address width
- SETUP, 1, setup cycles (1..15)
- STROBE, 2, strobe-low cycles (1..15)
- HOLD, 1, hold cycles (1..15)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock; all state changes on its rising edge
- reset, input, 1, asynchronous, active-high reset
- req, input, 1, host request, sampled only in IDLE
- rnw, input, 1, 1 = read, 0 = write; captured with req
- addr, input, AWIDTH, host address; captured with req
- wdata, input, DWIDTH, host write data; captured with req
- rdata, output, DWIDTH, read result; valid from the ack cycle until the next read completes
- ack, output, 1, one-cycle completion pulse
- busy, output, 1, high while a transaction is in progress
- sram_addr, output, AWIDTH, registered bus address
- sram_data, inout, DWIDTH, bus data; driven only during writes
- sram_ce_n, output, 1, active-low chip enable
- sram_we_n, output, 1, active-low write strobe; AVR ==> SRAM
- sram_oe_n, output, 1, active-low output enable; AVR <== SRAM

Function
REQ-003 The block SHALL be the initiator side of the WE/OE strobe protocol: it generates the strobes and data that a bus arbiter or SRAM responds to.
REQ-004 All bus outputs and the data-drive enable SHALL be registered, with no combinational path from inputs to strobes.
REQ-005 The FSM SHALL be one-hot with states IDLE, SETUP, STROBE, HOLD; a 4-bit down-counter SHALL time each phase.
REQ-006 IDLE: ce_n = we_n = oe_n = 1, sram_data = Z, busy = 0.
REQ-007 On a rising edge in IDLE with req = 1, the block SHALL capture addr/wdata/rnw, load sram_addr, and enter SETUP.
REQ-008 SETUP SHALL last exactly SETUP cycles with ce_n = 0 and strobes high; on writes, sram_data SHALL be driven with the captured wdata.
REQ-009 STROBE SHALL last exactly STROBE cycles with ce_n = 0; writes assert we_n = 0 and reads assert oe_n = 0, never both.
REQ-010 Reads SHALL sample sram_data into rdata on the clock edge that ends STROBE.
REQ-011 HOLD SHALL last exactly HOLD cycles with strobes high and ce_n = 0; writes keep driving data and sram_addr stays stable.
REQ-012 After HOLD the FSM SHALL return to IDLE, and ack SHALL be 1 for exactly that first IDLE cycle.
REQ-013 busy SHALL be 1 in SETUP, STROBE and HOLD only.
REQ-014 Latency: with req sampled at edge 0, ack SHALL be high in cycle SETUP+STROBE+HOLD+1; with defaults that is cycle 5.
REQ-015 req while busy SHALL be ignored, with no queuing.
REQ-016 req = 1 during the ack cycle SHALL start a new transaction at that edge; back-to-back transactions are separated by exactly one IDLE cycle with ce_n = 1.
REQ-017 sram_data SHALL be Z in every read state and in IDLE, so the block never drives during oe_n = 0.
REQ-018 rdata SHALL be unchanged by write transactions.

Reset
REQ-019 While reset = 1, independent of clk:
- state = IDLE
- ce_n = we_n = oe_n = 1
- sram_data = Z
- sram_addr = 0, rdata = 0
- busy = 0, ack = 0
REQ-020 Reset mid-transaction SHALL abort it immediately with strobes high; no ack SHALL be issued for it.
REQ-021 The first req SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-022 Write, defaults: addr = 0x12345, wdata = 0xA5, rnw = 0 -> sram_addr = 0x12345 and data = 0xA5 in cycles 1-4; we_n low in cycles 2-3 only; oe_n always 1; ack in cycle 5.
REQ-023 Read, defaults: SRAM model returns 0x3C while oe_n = 0 -> oe_n low in cycles 2-3; sram_data never driven by the DUT; rdata = 0x3C and ack in cycle 5.
REQ-024 req held high for three transactions -> three acks spaced 5 cycles apart, ce_n = 1 in each ack cycle; a req pulse in cycle 3 of an active transaction produces no extra transaction.
REQ-025 Reset asserted mid-cycle during write STROBE -> we_n = 1, ce_n = 1 and data Z before the next edge; ack never pulses; a new read after release completes normally.
REQ-026 SETUP = 2, STROBE = 1, HOLD = 3 -> we_n low for exactly 1 cycle starting cycle 3; ack in cycle 7.
